// File: rtl/cpr_mon_pkg.sv
// Shared types and default constants for the CPR rhythm monitor.
package cpr_mon_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSync,
    StCompress,
    StBreath
  } cpr_state_e;

  localparam int unsigned TickDivDef    = 10;
  localparam int unsigned PeriodWDef    = 16;
  localparam int unsigned CompPerCycDef = 30;
  localparam int unsigned BrthPerCycDef = 2;
  localparam int unsigned PeriodMinDef  = 50;
  localparam int unsigned PeriodMaxDef  = 70;
  localparam int unsigned TimeoutDef    = 1000;

  // Saturating 16-bit increment for the completed-cycle counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cpr_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// A pin rise produces a one-clock pulse three clocks later; a held level yields one pulse.
module cpr_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic pulse_o
);

  // [0] first sync stage, [1] second sync stage, [2] previous synchronised value
  logic [2:0] sync_q, sync_d;
  logic       pulse_q, pulse_d;

  // Shift the pin through the synchroniser and detect a 0->1 transition.
  always_comb begin
    sync_d  = {sync_q[1:0], d_i};
    pulse_d = sync_q[1] & ~sync_q[2];
  end

  // Synchroniser and pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cpr_rhythm_monitor.sv
// Receive-side checker for the CPR pacer strobes: measures the compression period, checks the
// compress/breath sequence and counts completed cycles.
// Optional feature: define CPR_MON_TIMEOUT_EN to enable the stalled-strobe timeout.
module cpr_rhythm_monitor
  import cpr_mon_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TickDivDef,
  parameter int unsigned PERIOD_W     = PeriodWDef,
  parameter int unsigned COMP_PER_CYC = CompPerCycDef,
  parameter int unsigned BRTH_PER_CYC = BrthPerCycDef,
  parameter int unsigned PERIOD_MIN   = PeriodMinDef,
  parameter int unsigned PERIOD_MAX   = PeriodMaxDef,
  parameter int unsigned TIMEOUT      = TimeoutDef
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                enable,
  input  logic                clear,
  input  logic                compress_in,
  input  logic                breath_in,
  input  logic                sync_in,
  output logic                busy,
  output logic                cycle_done,
  output logic [15:0]         cycle_count,
  output logic [7:0]          comp_count,
  output logic [PERIOD_W-1:0] last_period,
  output logic                err_rate,
  output logic                err_seq,
  output logic                err_timeout
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Reject nonsensical configurations at elaboration.
  if (TICK_DIV < 1 || PERIOD_MIN > PERIOD_MAX || TIMEOUT == 0) begin : g_bad_cfg
    $error("cpr_rhythm_monitor: invalid parameter set");
  end

  logic comp_e, brth_e, sync_e;

  cpr_edge_sync u_comp_sync (.clk_i(clk), .rst_ni(rstb), .d_i(compress_in), .pulse_o(comp_e));
  cpr_edge_sync u_brth_sync (.clk_i(clk), .rst_ni(rstb), .d_i(breath_in),   .pulse_o(brth_e));
  cpr_edge_sync u_sync_sync (.clk_i(clk), .rst_ni(rstb), .d_i(sync_in),     .pulse_o(sync_e));

  cpr_state_e          state_q, state_d;
  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d, last_q, last_d, meas;
  logic [7:0]          comp_q, comp_d, brth_q, brth_d;
  logic [15:0]         cyc_q, cyc_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                err_rate_q, err_rate_d, err_seq_q, err_seq_d, err_to_q, err_to_d;
  logic                tick;

  assign tick = busy_q && (tick_cnt_q == TickW'(TICK_DIV - 1));
  // Period as it stands including the tick of this clock, so an edge N ticks after the
  // previous one reads back N.
  assign meas = ((period_q != '1) && tick) ? period_q + 1'b1 : period_q;

  // Next-state: tick/period counters, sequence FSM, counts and sticky errors.
  always_comb begin
    state_d    = state_q;
    comp_d     = comp_q;
    brth_d     = brth_q;
    last_d     = last_q;
    done_d     = 1'b0;
    cyc_d      = clear ? 16'd0 : cyc_q;
    err_rate_d = clear ? 1'b0 : err_rate_q;
    err_seq_d  = clear ? 1'b0 : err_seq_q;
    err_to_d   = clear ? 1'b0 : err_to_q;
    tick_cnt_d = (busy_q && !tick) ? tick_cnt_q + 1'b1 : '0;
    period_d   = (tick && period_q != '1) ? period_q + 1'b1 : period_q;
    if (comp_e) period_d = '0;
`ifdef CPR_MON_TIMEOUT_EN
    if (brth_e) period_d = '0;
`endif
    if (!enable) begin
      state_d  = StIdle;
      comp_d   = '0;
      brth_d   = '0;
      period_d = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StWaitSync;
        StWaitSync: begin
          if (sync_e) begin
            state_d  = StCompress;
            comp_d   = '0;
            brth_d   = '0;
            period_d = '0;
          end
        end
        StCompress, StBreath: begin
          if (sync_e) begin
            if (comp_q != '0 || state_q == StBreath) err_seq_d = 1'b1;
            state_d  = StCompress;
            comp_d   = '0;
            brth_d   = '0;
            period_d = '0;
          end else if ((comp_e && brth_e) ||
                       (state_q == StCompress && brth_e) ||
                       (state_q == StBreath && comp_e)) begin
            err_seq_d = 1'b1;
            state_d   = StWaitSync;
            comp_d    = '0;
            brth_d    = '0;
          end else if (comp_e) begin
            // First compression of a cycle has no meaningful predecessor to measure against.
            if (comp_q != '0 &&
                (meas < PERIOD_W'(PERIOD_MIN) || meas > PERIOD_W'(PERIOD_MAX))) begin
              err_rate_d = 1'b1;
            end
            last_d = meas;
            comp_d = comp_q + 8'd1;
            if (comp_d == 8'(COMP_PER_CYC)) state_d = StBreath;
          end else if (brth_e) begin
            brth_d = brth_q + 8'd1;
            if (brth_d == 8'(BRTH_PER_CYC)) begin
              done_d  = 1'b1;
              cyc_d   = sat_inc16(cyc_d);
              comp_d  = '0;
              brth_d  = '0;
              state_d = StCompress;
            end
          end
`ifdef CPR_MON_TIMEOUT_EN
          else if (period_q >= PERIOD_W'(TIMEOUT)) begin
            err_to_d = 1'b1;
            state_d  = StWaitSync;
            comp_d   = '0;
            brth_d   = '0;
          end
`endif
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  // All monitor state and registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      period_q   <= '0;
      last_q     <= '0;
      comp_q     <= '0;
      brth_q     <= '0;
      cyc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_rate_q <= 1'b0;
      err_seq_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      period_q   <= period_d;
      last_q     <= last_d;
      comp_q     <= comp_d;
      brth_q     <= brth_d;
      cyc_q      <= cyc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_rate_q <= err_rate_d;
      err_seq_q  <= err_seq_d;
      err_to_q   <= err_to_d;
    end
  end

  assign busy        = busy_q;
  assign cycle_done  = done_q;
  assign cycle_count = cyc_q;
  assign comp_count  = comp_q;
  assign last_period = last_q;
  assign err_rate    = err_rate_q;
  assign err_seq     = err_seq_q;
`ifdef CPR_MON_TIMEOUT_EN
  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cpr_rhythm_monitor.sv
// Self-checking bench for cpr_rhythm_monitor: directed scenarios plus randomised strobe
// sequences checked against an event-level reference model.
module tb_cpr_rhythm_monitor;

  localparam int Timeout = 200;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        enable = 1'b0, clear = 1'b0;
  logic        compress_in = 1'b0, breath_in = 1'b0, sync_in = 1'b0;
  logic        busy, cycle_done, err_rate, err_seq, err_timeout;
  logic [15:0] cycle_count, last_period;
  logic [7:0]  comp_count;

  cpr_rhythm_monitor #(
    .TICK_DIV(1), .PERIOD_MIN(50), .PERIOD_MAX(70), .TIMEOUT(Timeout)
  ) dut (
    .clk(clk), .rstb(rstb), .enable(enable), .clear(clear),
    .compress_in(compress_in), .breath_in(breath_in), .sync_in(sync_in),
    .busy(busy), .cycle_done(cycle_done), .cycle_count(cycle_count),
    .comp_count(comp_count), .last_period(last_period),
    .err_rate(err_rate), .err_seq(err_seq), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_done = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cycle_done) n_done <= n_done + 1;

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. Mode: 0 idle, 1 waiting for sync, 2 compressions, 3 breaths.
  int m_mode = 0, m_comp = 0, m_brth = 0, m_last = 0, m_cycles = 0, m_done = 0;
  int m_zero_t = 0;
  bit m_rate = 0, m_seq = 0, m_to = 0;

  task automatic m_abort();
    m_seq = 1; m_mode = 1; m_comp = 0; m_brth = 0;
  endtask

  // Apply one set of simultaneous strobe edges first seen by the bench at cycle t.
  task automatic model_event(input bit c, input bit b, input bit s, input int t);
    int gap;
`ifdef CPR_MON_TIMEOUT_EN
    if (m_mode >= 2 && t - m_zero_t >= Timeout) begin
      m_to = 1; m_mode = 1; m_comp = 0; m_brth = 0;
    end
`endif
    gap = t - m_zero_t;
    if (m_mode == 1 && s) begin
      m_mode = 2; m_comp = 0; m_brth = 0; m_zero_t = t;
    end else if (m_mode >= 2) begin
      if (s) begin
        if (m_comp != 0 || m_mode == 3) m_seq = 1;
        m_mode = 2; m_comp = 0; m_brth = 0; m_zero_t = t;
      end else if (c && b) m_abort();
      else if (m_mode == 2 && b) m_abort();
      else if (m_mode == 3 && c) m_abort();
      else if (c) begin
        if (m_comp != 0 && (gap < 50 || gap > 70)) m_rate = 1;
        m_last = gap;
        m_comp++;
        if (m_comp == 30) m_mode = 3;
      end else if (b) begin
        m_brth++;
        if (m_brth == 2) begin
          m_done++; m_cycles++; m_comp = 0; m_brth = 0; m_mode = 2;
        end
      end
    end
    if (c && m_mode != 0) m_zero_t = t;
`ifdef CPR_MON_TIMEOUT_EN
    if (b && m_mode != 0) m_zero_t = t;
`endif
  endtask

  task automatic check_all(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'(m_mode != 0));
    if (m_mode != 1) check({tag, ".comp_count"}, 32'(comp_count), 32'(m_comp));
    check({tag, ".cycle_count"}, 32'(cycle_count), 32'(m_cycles));
    check({tag, ".last_period"}, 32'(last_period), 32'(m_last));
    check({tag, ".err_rate"}, 32'(err_rate), 32'(m_rate));
    check({tag, ".err_seq"}, 32'(err_seq), 32'(m_seq));
    check({tag, ".err_timeout"}, 32'(err_timeout), 32'(m_to));
    check({tag, ".done_pulses"}, 32'(n_done), 32'(m_done));
  endtask

  // Raise the chosen pins for three clocks; the next strobe rises `gap` clocks later.
  task automatic strobe(input bit c, input bit b, input bit s, input int gap, input string tag);
    @(posedge clk); #1;
    compress_in = c; breath_in = b; sync_in = s;
    model_event(c, b, s, cyc);
    repeat (3) @(posedge clk);
    #1;
    compress_in = 0; breath_in = 0; sync_in = 0;
    repeat (gap - 4) @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic run_comps(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) strobe(1, 0, 0, $urandom_range(hi, lo), "comp");
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1;
    @(posedge clk); #1 clear = 0;
    m_rate = 0; m_seq = 0; m_to = 0; m_cycles = 0;
    check_all("clear");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rstb = 1;
    @(posedge clk); #1 enable = 1;
    @(posedge clk); #1;
    m_mode = 1;
    check("enable.busy", 32'(busy), 32'd1);

    // 1: clean cycle at 60-clk spacing.
    strobe(0, 0, 1, 60, "t1.sync");
    for (int i = 0; i < 30; i++) strobe(1, 0, 0, 60, "t1.comp");
    strobe(0, 1, 0, 30, "t1.br");
    strobe(0, 1, 0, 30, "t1.br");
    check("t1.cycles", 32'(cycle_count), 32'd1);
    check("t1.last_period", 32'(last_period), 32'd60);
    check("t1.err_rate", 32'(err_rate), 32'd0);

    // 2: fifth compression arrives 40 clk after the fourth.
    for (int i = 0; i < 30; i++) strobe(1, 0, 0, (i == 3) ? 40 : 60, "t2.comp");
    strobe(0, 1, 0, 30, "t2.br");
    strobe(0, 1, 0, 30, "t2.br");
    check("t2.err_rate", 32'(err_rate), 32'd1);
    check("t2.cycles", 32'(cycle_count), 32'd2);

    // 3: breath after 12 compressions, then a sync resumes.
    run_comps(12, 55, 65);
    strobe(0, 1, 0, 30, "t3.br");
    check("t3.err_seq", 32'(err_seq), 32'd1);
    check("t3.busy", 32'(busy), 32'd1);
    strobe(1, 0, 0, 60, "t3.ignored");
    strobe(0, 0, 1, 60, "t3.sync");

    // 4: sync mid-cycle after 10 compressions, then a full cycle.
    run_comps(10, 55, 65);
    strobe(0, 0, 1, 60, "t4.sync");
    check("t4.comp_count", 32'(comp_count), 32'd0);
    check("t4.cycles", 32'(cycle_count), 32'd2);
    run_comps(30, 52, 68);
    strobe(0, 1, 0, 25, "t4.br");
    strobe(0, 1, 0, 25, "t4.br");

    // 5: clear with err_rate set and three cycles, then disable.
    check("t5.pre_cycles", 32'(cycle_count), 32'd3);
    pulse_clear();
    check("t5.err_rate", 32'(err_rate), 32'd0);
    check("t5.cycles", 32'(cycle_count), 32'd0);
    @(posedge clk); #1 enable = 0;
    @(posedge clk); #1;
    m_mode = 0; m_comp = 0; m_brth = 0;
    check("t5.busy", 32'(busy), 32'd0);
    check_all("t5.idle");
    @(posedge clk); #1 enable = 1;
    @(posedge clk); #1;
    m_mode = 1;

    // Randomised sequences.
    for (int it = 0; it < 12; it++) begin
      int kind;
      kind = $urandom_range(5, 0);
      case (kind)
        0: begin
          strobe(0, 0, 1, $urandom_range(80, 20), "r.sync");
          run_comps(30, 48, 72);
          strobe(0, 1, 0, $urandom_range(80, 20), "r.br");
          strobe(0, 1, 0, $urandom_range(80, 20), "r.br");
        end
        1: begin
          strobe(0, 0, 1, 40, "r.sync");
          run_comps($urandom_range(29, 1), 50, 70);
          strobe(0, 1, 0, 40, "r.stray_br");
        end
        2: begin
          strobe(0, 0, 1, 40, "r.sync");
          run_comps($urandom_range(20, 0), 50, 70);
          strobe(0, 0, 1, 40, "r.mid_sync");
        end
        3: begin
          strobe(0, 0, 1, 40, "r.sync");
          run_comps($urandom_range(10, 1), 50, 70);
          strobe(1, 1, 0, 40, "r.both");
        end
        4: begin
          strobe(0, 0, 1, 40, "r.sync");
          run_comps(30, 50, 70);
          strobe(1, 0, 0, 40, "r.comp_in_br");
        end
        default: pulse_clear();
      endcase
    end

    // 6: stall after one compression.
    strobe(0, 0, 1, 60, "t6.sync");
    strobe(1, 0, 0, Timeout + 30, "t6.comp");
    model_event(0, 0, 0, cyc);
    check_all("t6.stall");
`ifdef CPR_MON_TIMEOUT_EN
    check("t6.err_timeout", 32'(err_timeout), 32'd1);
`else
    check("t6.err_timeout", 32'(err_timeout), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
